// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding, line levels and,
// when UART_TX_PARITY_EN is defined, the even-parity helper.
package uart_pkg;

  // Transmit FSM states. PARITY exists only when the parity bit is built in.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } tx_state_e;

  // Level of an idle line and of the start bit.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

`ifdef UART_TX_PARITY_EN
  // Even parity over a zero-extended data word (extra zeros do not change it).
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

endpackage

// File: rtl/uart_tx_shreg.sv
// Data shift register and bit counter for the UART transmitter.
// The register holds the bits not yet driven onto the line: data_r[0] is
// the next data bit to launch. The counter is the index of the data bit
// currently on the line, and last flags the final data bit.
module uart_tx_shreg
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 shift,
  input  logic                 count,
  output logic                 bit_out,
  output logic                 last
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BITS - 1);

  logic [DATA_BITS-1:0] data_r;
  logic [CW-1:0]        cnt_r;

  // Load on acceptance, shift right as each data bit is launched, count bits on the line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r <= '0;
      cnt_r  <= '0;
    end else if (load) begin
      data_r <= din;
      cnt_r  <= '0;
    end else begin
      if (shift) begin
        data_r <= {LINE_IDLE, data_r[DATA_BITS-1:1]};
      end
      if (count) begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign bit_out = data_r[0];
  assign last    = (cnt_r == LAST_IDX);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a word through a valid/ready handshake,
// enables an external baud tick generator and shifts out
// start, data (LSB first), optional parity and stop bits on the tick.
// Define UART_TX_PARITY_EN to add an even parity bit after the data bits.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 bps_en,
  input  logic                 bps_clk,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_e state_r;
  tx_state_e state_s;
  logic      tx_r;
  logic      tx_s;
  logic      ready_r;
  logic      busy_r;
  logic      bps_en_r;
  logic      stop_cnt_r;
  logic      accept_s;
  logic      shift_s;
  logic      count_s;
  logic      bit_s;
  logic      last_s;

  // A request is taken only in IDLE; ready is a registered copy of "in IDLE".
  assign accept_s = (state_r == IDLE) && tx_valid;
  // Launching a data bit happens on the START tick and on every DATA tick.
  assign shift_s  = bps_clk && ((state_r == START) || (state_r == DATA));
  assign count_s  = bps_clk && (state_r == DATA) && !last_s;

  uart_tx_shreg #(
    .DATA_BITS(DATA_BITS)
  ) u_shreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept_s),
    .din    (tx_data),
    .shift  (shift_s),
    .count  (count_s),
    .bit_out(bit_s),
    .last   (last_s)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_r;

  // Capture the even parity of the word at acceptance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_r <= 1'b0;
    end else if (accept_s) begin
      parity_r <= even_parity(8'(tx_data));
    end
  end
`endif

  // Next state and next line level; the line level is registered below
  always_comb begin
    state_s = state_r;
    tx_s    = tx_r;
    case (state_r)
      IDLE: begin
        if (tx_valid) begin
          state_s = START;
          tx_s    = START_BIT;
        end else begin
          state_s = IDLE;
          tx_s    = LINE_IDLE;
        end
      end
      START: begin
        if (bps_clk) begin
          state_s = DATA;
          tx_s    = bit_s;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bps_clk) begin
          if (last_s) begin
`ifdef UART_TX_PARITY_EN
            state_s = PARITY;
            tx_s    = parity_r;
`else
            state_s = STOP;
            tx_s    = LINE_IDLE;
`endif
          end else begin
            state_s = DATA;
            tx_s    = bit_s;
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bps_clk) begin
          state_s = STOP;
          tx_s    = LINE_IDLE;
        end else begin
          state_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (bps_clk && (stop_cnt_r == STOP_LAST)) begin
          state_s = IDLE;
          tx_s    = LINE_IDLE;
        end else begin
          state_s = STOP;
          tx_s    = LINE_IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        tx_s    = LINE_IDLE;
      end
    endcase
  end

  // State, line and handshake registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      tx_r     <= LINE_IDLE;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      bps_en_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      tx_r     <= tx_s;
      ready_r  <= (state_s == IDLE);
      busy_r   <= (state_s != IDLE);
      bps_en_r <= (state_s != IDLE);
    end
  end

  // Count stop-bit ticks; cleared whenever the frame is outside STOP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stop_cnt_r <= 1'b0;
    end else if (state_r != STOP) begin
      stop_cnt_r <= 1'b0;
    end else if (bps_clk) begin
      stop_cnt_r <= stop_cnt_r + 1'b1;
    end
  end

  assign tx       = tx_r;
  assign tx_ready = ready_r;
  assign tx_busy  = busy_r;
  assign bps_en   = bps_en_r;

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter DATA_BITS, default 8, the number of data bits per frame; legal values are 5 to 8.
REQ-002 Parameter STOP_BITS, default 1, the number of stop bits per frame; legal values are 1 and 2.
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port tx_valid, input, 1 bit: a transmit request from upstream.
REQ-006 The module SHALL have port tx_data, input, DATA_BITS wide: the byte to send; it is valid while tx_valid is high.
REQ-007 The module SHALL have port tx_ready, output, 1 bit: high when a request can be accepted.
REQ-008 The module SHALL have port bps_en, output, 1 bit: the enable to the external baud tick generator.
REQ-009 The module SHALL have port bps_clk, input, 1 bit: a one-cycle baud tick from the generator.
REQ-010 The module SHALL have port tx, output, 1 bit: the serial line, which idles high.
REQ-011 The module SHALL have port tx_busy, output, 1 bit: high while a frame is in flight.

Function
REQ-012 The state machine SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-013 A request SHALL be accepted on a clk edge where tx_valid is high and tx_ready is high.
- On acceptance, tx_data is latched into the shift register and the state moves to START.
- On the following cycle, tx=0, bps_en=1, tx_ready=0 and tx_busy=1.
REQ-014 tx_ready SHALL be high only in IDLE.
- tx_valid outside IDLE is ignored.
- tx_data changes outside the acceptance cycle have no effect.
REQ-015 The state SHALL advance only on cycles where bps_clk=1; each bit lasts from one tick to the next.
REQ-016 The START to DATA transition SHALL occur on the first tick, and tx then drives data bit 0.
- Data is sent LSB first.
- A bit counter (width $clog2(DATA_BITS)) advances on each tick.
REQ-017 After DATA_BITS data ticks, the state SHALL go to PARITY when the parity feature is compiled in, and otherwise to STOP.
REQ-018 STOP SHALL drive tx=1 for STOP_BITS ticks, then go to IDLE with bps_en=0, tx_ready=1 and tx_busy=0.
REQ-019 A bps_clk pulse in IDLE SHALL be ignored.
REQ-020 tx SHALL be registered, with no combinational path from any input to tx.
REQ-021 Back-to-back frames:
- A tx_valid held high across the return to IDLE is accepted on the first IDLE cycle.
- The minimum idle gap between frames is therefore one clk cycle, at tx=1.

Reset
REQ-022 When rst_n=0 at a clk edge, the outputs SHALL be tx=1, tx_ready=1, tx_busy=0 and bps_en=0, with the state IDLE and the counters at 0.
REQ-023 A reset mid-frame SHALL abort the frame immediately.
- tx returns high on that edge.
- The partial frame is not resumed.
REQ-024 While rst_n=0, tx_valid SHALL be ignored.

Configuration
REQ-025 Macro UART_TX_PARITY_EN, when defined, SHALL enable a parity bit after the last data bit.
- The parity bit is even parity: the XOR of the DATA_BITS data bits.
- Parity is computed at acceptance.
REQ-026 Without UART_TX_PARITY_EN, there SHALL be no PARITY state, no parity logic and no parity bit in the frame.

Structure
REQ-027 Package uart_pkg SHALL hold the shared UART definitions:
- the tx state enum type;
- the line idle level constant (1'b1);
- the start bit level constant (1'b0).
REQ-028 One sub-module, uart_tx_shreg, SHALL hold the DATA_BITS-wide load/shift register and the bit counter.
- It is loaded on acceptance.
- It shifts right on each DATA tick.
- It outputs the current bit and a last-bit flag.
REQ-029 The baud tick generator SHALL remain external, connected only through bps_en and bps_clk.

Verification
REQ-030 Single frame: DATA_BITS=8, tx_data=8'hA5, bench ticks every 16 cycles -> tx is 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1; each bit lasts 16 cycles; tx_ready returns to 1 after the stop tick.
REQ-031 Busy rejection: a second tx_valid with 8'h3C during the DATA state of the 8'hA5 frame -> tx_ready stays 0, 8'h3C is never sent, and the 8'hA5 frame is unaltered.
REQ-032 Back-to-back: tx_valid held high with 8'h01 then 8'hFF -> both frames are sent, and the gap between the stop bit of the first and the start bit of the second is exactly 1 clk at tx=1.
REQ-033 Mid-frame reset: rst_n=0 for 1 cycle during data bit 3 -> on the next edge tx=1, bps_en=0 and tx_ready=1; the next request, 8'h55, is sent correctly.
REQ-034 Parity, with UART_TX_PARITY_EN defined: 8'h07 -> parity bit 1; 8'h03 -> parity bit 0; the frame is 11 bits long with STOP_BITS=1.
REQ-035 Spurious ticks and configuration corners:
- bps_clk pulses while idle -> tx stays 1 and no state change occurs.
- STOP_BITS=2 -> the stop level lasts 2 ticks.
- DATA_BITS=5 -> only 5 data bits are sent.
